id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that consumes the register file's two read ports, together with the decoded fields and control bits of the instruction in ID.
- Registers all of it into the EX stage.
- Contains the load-use hazard detector: stalls IF/ID and injects a bubble into EX.
- Honours branch-flush requests from EX.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_NUM, 32, number of architectural registers; ADDR_W = $clog2(REG_NUM).
- CTRL_W, 8, width of the opaque control bundle passed from decode to EX.

Ports:
- clk  input  1  stage clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_readData1  input  DATA_W  register file read port 1 (rs value).
- id_readData2  input  DATA_W  register file read port 2 (rt value).
- id_rs, id_rt, id_rd  input  ADDR_W  decoded register specifiers.
- id_usesRt  input  1  instruction reads rt as a source.
- id_imm  input  DATA_W  sign-extended immediate.
- id_memRead  input  1  instruction is a load.
- id_ctrl  input  CTRL_W  remaining decode controls (regWrite, memWrite, aluOp, ...).
- flush  input  1  branch/jump resolved taken in EX; kill the ID instruction.
- wb_regWrite  input  1  writeback stage write enable (the register file writeEnable).
- wb_writeAddr  input  ADDR_W  writeback destination.
- wb_writeData  input  DATA_W  writeback data.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- ex_valid, ex_memRead  output  1  registered.
- ex_ctrl  output  CTRL_W  registered.
- ex_rsData, ex_rtData, ex_imm  output  DATA_W  registered.
- ex_rs, ex_rt, ex_rd  output  ADDR_W  registered.

Behaviour:
- Reset (sync, high): all ex_* outputs go to 0, including ex_valid=0 and ex_ctrl=0. stall is 0 while reset is high.
- Latency: one cycle. ID values present at edge N appear on ex_* after edge N.
- Hazard condition:
  - hazard = ex_valid & ex_memRead & (ex_rt != 0) & (ex_rt == id_rs | (id_usesRt & ex_rt == id_rt)) & id_valid.
  - Register 0 never causes a hazard.
- stall = hazard & ~flush & ~reset.
- Update priority at each posedge: reset > flush > hazard > load.
  - flush: insert a bubble (ex_valid=0, ex_memRead=0, ex_ctrl=0). Data/address fields are don't-care but driven to 0. The wrong-path instruction is discarded, and stall is not raised.
  - hazard: insert a bubble. The ID instruction stays in ID because stall is high, and it is re-evaluated next cycle. A load-use hazard therefore costs exactly one bubble, since the load then moves to MEM.
  - otherwise: capture every id_* input. ex_valid = id_valid. ex_memRead = id_memRead & id_valid. ex_ctrl = id_valid ? id_ctrl : 0.
- Bubbles always carry zero control, so no register or memory write can occur downstream.
- Simultaneous flush and hazard: flush wins and stall=0.
- Reset mid-stall: the stall is dropped immediately and the bubble state is cleared.
- No internal storage other than the EX register set; the block introduces no extra state machine latency.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: explicit WB-to-ID bypass. If wb_regWrite & wb_writeAddr != 0 & wb_writeAddr == id_rs, ex_rsData captures wb_writeData instead of id_readData1. The same rule applies to id_rt and ex_rtData. The bypass is applied only on the load path (not on bubbles).
- Undefined: ex_rsData/ex_rtData come from id_readData1/2 unchanged. Correctness then relies on the register file's negedge write-before-read.
- The wb_* ports exist in both builds; they are unused when the macro is undefined.

Decomposition:
- Shared package mips_pkg:
  - DATA_W, REG_NUM, ADDR_W constants.
  - CTRL_W and control-bundle bit indices.
  - BUBBLE_CTRL constant (all zeros).
- Sub-module hazard_detect_unit: purely combinational load-use compare producing hazard. It is reused later by the forwarding/hazard top.

Test Plan:
- Reset: drive reset=1 for 2 cycles with id_valid=1 and id_ctrl=8'hFF -> all ex_* are 0 and stall=0. Release reset; the next edge captures the ID inputs.
- Plain pipeline: id_rs=5, id_readData1=32'h1234, id_imm=32'hFFFF_FFF0, id_valid=1 -> one edge later ex_rsData=32'h1234, ex_imm=32'hFFFF_FFF0, ex_rs=5, ex_valid=1.
- Load-use stall: EX holds a load with ex_rt=8; ID has id_rs=8 -> stall=1 in that cycle and the next ex_valid=0 with ex_ctrl=0. The following cycle stall=0 and the instruction is captured.
- Register-zero and no-use cases:
  - ex load with ex_rt=0, id_rs=0 -> stall=0.
  - ex_rt=9, id_rt=9, id_usesRt=0 -> stall=0.
- Flush vs hazard: hazard condition true and flush=1 in the same cycle -> stall=0, bubble in EX, ID instruction not captured.
- Bypass (ID_WB_BYPASS_EN): wb_regWrite=1, wb_writeAddr=3, wb_writeData=32'hCAFE, id_rt=3, id_readData2=32'h0 -> ex_rtData=32'hCAFE.
  - Without the macro -> ex_rtData=32'h0.
  - With the macro and wb_writeAddr=0 -> no bypass.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths and the decode control bundle layout.
package mips_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned ADDR_W  = $clog2(REG_NUM);
    localparam int unsigned CTRL_W  = 8;

    // Bit positions inside the opaque control bundle carried from decode to EX.
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_ALUSRC   = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_ALUOP_LO = 4;
    localparam int unsigned CTRL_ALUOP_W  = 4;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect_unit #(
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              ex_valid,
    input  logic              ex_memRead,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_usesRt,
    output logic              hazard
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hard-wired, so a load targeting it never blocks a consumer.
    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_usesRt & (ex_rt == id_rt);
    assign hazard   = ex_valid & ex_memRead & (ex_rt != '0) & (rs_match | rt_match) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble and EX branch flush.
// Optional macro ID_WB_BYPASS_EN adds a WB-to-ID operand bypass on the capture path.
module id_ex_stage #(
    parameter int unsigned DATA_W  = mips_pkg::DATA_W,
    parameter int unsigned REG_NUM = mips_pkg::REG_NUM,
    parameter int unsigned CTRL_W  = mips_pkg::CTRL_W,
    localparam int unsigned ADDR_W = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_readData1,
    input  logic [DATA_W-1:0] id_readData2,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_usesRt,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_memRead,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              wb_regWrite,
    input  logic [ADDR_W-1:0] wb_writeAddr,
    input  logic [DATA_W-1:0] wb_writeData,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_memRead,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rsData,
    output logic [DATA_W-1:0] ex_rtData,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd
);

    import mips_pkg::*;

    logic              hazard;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    hazard_detect_unit #(
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .ex_valid   (ex_valid),
        .ex_memRead (ex_memRead),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_usesRt  (id_usesRt),
        .hazard     (hazard)
    );

    // Flush outranks the hazard: the wrong-path instruction is dropped, not held.
    assign stall = hazard & ~flush & ~reset;

`ifdef ID_WB_BYPASS_EN
    logic wb_hit_rs;
    logic wb_hit_rt;

    assign wb_hit_rs = wb_regWrite & (wb_writeAddr != '0) & (wb_writeAddr == id_rs);
    assign wb_hit_rt = wb_regWrite & (wb_writeAddr != '0) & (wb_writeAddr == id_rt);
    assign rs_data   = wb_hit_rs ? wb_writeData : id_readData1;
    assign rt_data   = wb_hit_rt ? wb_writeData : id_readData2;
`else
    // The register file writes on negedge, so same-cycle WB data is already visible.
    logic unused_wb;

    assign unused_wb = ^{wb_regWrite, wb_writeAddr, wb_writeData};
    assign rs_data   = id_readData1;
    assign rt_data   = id_readData2;
`endif

    // EX register set; reset, flush and hazard all leave a zero-control bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || hazard) begin
            ex_valid   <= 1'b0;
            ex_memRead <= 1'b0;
            ex_ctrl    <= CTRL_W'(BUBBLE_CTRL);
            ex_rsData  <= '0;
            ex_rtData  <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else begin
            ex_valid   <= id_valid;
            ex_memRead <= id_memRead & id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : CTRL_W'(BUBBLE_CTRL);
            ex_rsData  <= rs_data;
            ex_rtData  <= rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model feeds a scoreboard queue of EX contents.
// Honours ID_WB_BYPASS_EN so the same bench covers both builds.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic        mr;
        logic [7:0]  ctrl;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_readData1;
    logic [31:0] id_readData2;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_usesRt;
    logic [31:0] id_imm;
    logic        id_memRead;
    logic [7:0]  id_ctrl;
    logic        flush;
    logic        wb_regWrite;
    logic [4:0]  wb_writeAddr;
    logic [31:0] wb_writeData;
    logic        stall;
    logic        ex_valid;
    logic        ex_memRead;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_rsData;
    logic [31:0] ex_rtData;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;

    int   total = 0;
    int   bad   = 0;
    ex_t  m     = '0;
    ex_t  sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_readData1 (id_readData1),
        .id_readData2 (id_readData2),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_usesRt    (id_usesRt),
        .id_imm       (id_imm),
        .id_memRead   (id_memRead),
        .id_ctrl      (id_ctrl),
        .flush        (flush),
        .wb_regWrite  (wb_regWrite),
        .wb_writeAddr (wb_writeAddr),
        .wb_writeData (wb_writeData),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_memRead   (ex_memRead),
        .ex_ctrl      (ex_ctrl),
        .ex_rsData    (ex_rsData),
        .ex_rtData    (ex_rtData),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check comb stall, push predicted EX contents, compare after the edge.
    task automatic run_cycle(input string tag);
        ex_t  e;
        ex_t  got;
        logic hz;
        logic st;
        hz = m.v && m.mr && (m.rt != 5'd0) && id_valid &&
             ((m.rt == id_rs) || (id_usesRt && (m.rt == id_rt)));
        st = hz && !flush && !reset;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        e = '0;
        if (!(reset || flush || hz)) begin
            e.v    = id_valid;
            e.mr   = id_memRead & id_valid;
            e.ctrl = id_valid ? id_ctrl : 8'h00;
            e.rsd  = id_readData1;
            e.rtd  = id_readData2;
`ifdef ID_WB_BYPASS_EN
            if (wb_regWrite && wb_writeAddr != 5'd0 && wb_writeAddr == id_rs) e.rsd = wb_writeData;
            if (wb_regWrite && wb_writeAddr != 5'd0 && wb_writeAddr == id_rt) e.rtd = wb_writeData;
`endif
            e.imm  = id_imm;
            e.rs   = id_rs;
            e.rt   = id_rt;
            e.rd   = id_rd;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, "_valid"}, 32'(ex_valid), 32'(got.v));
        chk({tag, "_memRead"}, 32'(ex_memRead), 32'(got.mr));
        chk({tag, "_ctrl"}, 32'(ex_ctrl), 32'(got.ctrl));
        chk({tag, "_rsData"}, ex_rsData, got.rsd);
        chk({tag, "_rtData"}, ex_rtData, got.rtd);
        chk({tag, "_imm"}, ex_imm, got.imm);
        chk({tag, "_rs"}, 32'(ex_rs), 32'(got.rs));
        chk({tag, "_rt"}, 32'(ex_rt), 32'(got.rt));
        chk({tag, "_rd"}, 32'(ex_rd), 32'(got.rd));
        m = got;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic uses_rt, input logic mem_rd,
                          input logic [7:0] ctrl);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_usesRt  = uses_rt;
        id_memRead = mem_rd;
        id_ctrl    = ctrl;
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        wb_regWrite  = 1'b0;
        wb_writeAddr = 5'd0;
        wb_writeData = 32'h0;
        id_readData1 = 32'hAAAA_0001;
        id_readData2 = 32'hBBBB_0002;
        id_imm       = 32'h0000_0010;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'hFF);

        // Reset held for two cycles with a live instruction in ID.
        run_cycle("reset0");
        run_cycle("reset1");
        chk("reset_ctrl_zero", 32'(ex_ctrl), 32'h0);
        chk("reset_valid_zero", 32'(ex_valid), 32'h0);
        reset = 1'b0;

        // Plain capture.
        id_readData1 = 32'h0000_1234;
        id_imm       = 32'hFFFF_FFF0;
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 8'h21);
        run_cycle("plain");
        chk("plain_rsData_lit", ex_rsData, 32'h0000_1234);
        chk("plain_imm_lit", ex_imm, 32'hFFFF_FFF0);
        chk("plain_rs_lit", 32'(ex_rs), 32'd5);

        // Load-use: load to r8 then consumer of r8 -> one bubble, then capture.
        set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b0, 1'b1, 8'h09);
        run_cycle("load8");
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b0, 8'h31);
        #1;
        chk("lu_stall_lit", 32'(stall), 32'd1);
        run_cycle("lu_bubble");
        chk("lu_bubble_valid_lit", 32'(ex_valid), 32'd0);
        run_cycle("lu_capture");
        chk("lu_capture_rs_lit", 32'(ex_rs), 32'd8);

        // Load to r0 never stalls.
        set_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 8'h09);
        run_cycle("load0");
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 8'h01);
        run_cycle("zero_nostall");

        // rt match without usesRt does not stall.
        set_id(1'b1, 5'd4, 5'd9, 5'd0, 1'b0, 1'b1, 8'h09);
        run_cycle("load9");
        set_id(1'b1, 5'd1, 5'd9, 5'd12, 1'b0, 1'b0, 8'h01);
        run_cycle("norttuse");
        chk("norttuse_valid_lit", 32'(ex_valid), 32'd1);

        // Flush and hazard together: flush wins, bubble, no stall.
        set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b0, 1'b1, 8'h09);
        run_cycle("load8b");
        set_id(1'b1, 5'd8, 5'd8, 5'd13, 1'b1, 1'b0, 8'h41);
        flush = 1'b1;
        run_cycle("flush_hz");
        chk("flush_valid_lit", 32'(ex_valid), 32'd0);
        flush = 1'b0;

        // WB bypass on rt, then with write address 0.
        wb_regWrite  = 1'b1;
        wb_writeAddr = 5'd3;
        wb_writeData = 32'h0000_CAFE;
        id_readData2 = 32'h0;
        set_id(1'b1, 5'd1, 5'd3, 5'd14, 1'b1, 1'b0, 8'h01);
        run_cycle("bypass");
`ifdef ID_WB_BYPASS_EN
        chk("bypass_rt_lit", ex_rtData, 32'h0000_CAFE);
`else
        chk("bypass_rt_lit", ex_rtData, 32'h0);
`endif
        wb_writeAddr = 5'd0;
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 8'h01);
        run_cycle("bypass_r0");
        chk("bypass_r0_lit", ex_rtData, 32'h0);
        wb_regWrite = 1'b0;

        // Reset while a stall would be raised.
        set_id(1'b1, 5'd4, 5'd8, 5'd0, 1'b0, 1'b1, 8'h09);
        run_cycle("load8c");
        set_id(1'b1, 5'd8, 5'd1, 5'd15, 1'b1, 1'b0, 8'h41);
        reset = 1'b1;
        run_cycle("reset_stall");
        reset = 1'b0;

        // Randomised traffic over a small register range to hit hazards often.
        for (int i = 0; i < 300; i++) begin
            id_readData1 = $urandom;
            id_readData2 = $urandom;
            id_imm       = $urandom;
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom));
            flush        = ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 29) == 0);
            wb_regWrite  = 1'($urandom_range(0, 1));
            wb_writeAddr = 5'($urandom_range(0, 3));
            wb_writeData = $urandom;
            run_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
